net_resolve_sampler: RTL

- Parametrised, clocked net-resolution engine for the generated-netlist test flow.
- Takes NCH channels, each driving a W-bit value with a per-bit drive enable.
- Resolves them per the selected net kind (tri, wand, wor, tri0, tri1, trireg) into a registered 4-state result, encoded as value/x/z planes.
- Sits between the driver-model stimulus and the net-checker scoreboard, behind valid/ready handshakes.

---
 rtl/net_resolve_sampler_if.sv | 28 ++
 rtl/net_resolve_sampler.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/net_resolve_sampler_if.sv
// Handshake and bus bundle for net_resolve_sampler.
// master: driver-model / checker side, slave: the resolver itself.
interface net_resolve_sampler_if #(
  parameter int NCH = 4,
  parameter int W   = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [NCH*W-1:0] drv_val;
  logic [NCH*W-1:0] drv_oe;
  logic [NCH*W-1:0] drv_x;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     res_val;
  logic [W-1:0]     res_x;
  logic [W-1:0]     res_z;
  logic             conflict;

  modport master (
    output in_valid, drv_val, drv_oe, drv_x, out_ready,
    input  in_ready, out_valid, res_val, res_x, res_z, conflict
  );

  modport slave (
    input  in_valid, drv_val, drv_oe, drv_x, out_ready,
    output in_ready, out_valid, res_val, res_x, res_z, conflict
  );
endinterface

// File: rtl/net_resolve_sampler.sv
// net_resolve_sampler: resolves NCH W-bit drivers into a registered
// 4-state net value (value/x/z planes) for tri, wand, wor, tri0, tri1 and
// trireg nets, behind a one-deep valid/ready output register.
// Optional transfer/conflict/decay statistics counters are enabled by
// defining NET_RESOLVE_STATS_EN.
module net_resolve_sampler #(
  parameter int NCH   = 4,
  parameter int W     = 8,
  parameter int MODE  = 0,
  parameter int DECAY = 3
) (
  input logic clk,
  input logic rst,
  net_resolve_sampler_if.slave bus
`ifdef NET_RESOLVE_STATS_EN
  ,
  output logic [15:0] stat_xfer,
  output logic [15:0] stat_conflict,
  output logic [15:0] stat_decay
`endif
);

  localparam logic [7:0] DECAY_C = 8'(DECAY);

  logic         xfer;
  logic [W-1:0] any_drv, any_x, any0, any1;
  logic [W-1:0] tri_x, tri_v;
  logic [W-1:0] nxt_val, nxt_x, nxt_z;
  logic [W-1:0] charge_val, charge_x, nxt_cval, nxt_cx;
  logic [W-1:0] decayed;
  logic [7:0]   cnt     [W];
  logic [7:0]   nxt_cnt [W];
  logic         conflict_nxt;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign xfer         = bus.in_valid && bus.in_ready;

  // Per-bit summary of the active drivers: anyone driving, any X, any clean 0, any clean 1.
  always_comb begin
    any_drv = '0;
    any_x   = '0;
    any0    = '0;
    any1    = '0;
    for (int c = 0; c < NCH; c++) begin
      any_drv = any_drv | bus.drv_oe[c*W +: W];
      any_x   = any_x | (bus.drv_oe[c*W +: W] & bus.drv_x[c*W +: W]);
      any0    = any0 | (bus.drv_oe[c*W +: W] & ~bus.drv_x[c*W +: W] & ~bus.drv_val[c*W +: W]);
      any1    = any1 | (bus.drv_oe[c*W +: W] & ~bus.drv_x[c*W +: W] & bus.drv_val[c*W +: W]);
    end
  end

  assign tri_x        = any_x | (any0 & any1);
  assign tri_v        = any1 & ~tri_x;
  assign conflict_nxt = |(any0 & any1);

  // Net-kind resolution plus the trireg charge/decay bookkeeping for the next transfer.
  always_comb begin
    nxt_val  = '0;
    nxt_x    = '0;
    nxt_z    = '0;
    nxt_cval = charge_val;
    nxt_cx   = charge_x;
    nxt_cnt  = cnt;
    decayed  = '0;
    for (int b = 0; b < W; b++) begin
      case (MODE)
        1: begin
          if (!any_drv[b]) nxt_z[b] = 1'b1;
          else if (!any0[b]) begin
            if (any_x[b]) nxt_x[b] = 1'b1;
            else          nxt_val[b] = 1'b1;
          end
        end
        2: begin
          if (!any_drv[b])   nxt_z[b] = 1'b1;
          else if (any1[b])  nxt_val[b] = 1'b1;
          else if (any_x[b]) nxt_x[b] = 1'b1;
        end
        5: begin
          if (any_drv[b]) begin
            nxt_val[b]  = tri_v[b];
            nxt_x[b]    = tri_x[b];
            nxt_cval[b] = tri_v[b];
            nxt_cx[b]   = tri_x[b];
            nxt_cnt[b]  = '0;
          end else if (cnt[b] < DECAY_C) begin
            nxt_val[b] = charge_val[b];
            nxt_x[b]   = charge_x[b];
            nxt_cnt[b] = cnt[b] + 8'd1;
          end else begin
            nxt_x[b]    = 1'b1;
            nxt_cval[b] = 1'b0;
            nxt_cx[b]   = 1'b1;
            decayed[b]  = !charge_x[b];
          end
        end
        default: begin
          if (any_drv[b]) begin
            nxt_val[b] = tri_v[b];
            nxt_x[b]   = tri_x[b];
          end else if (MODE == 4) nxt_val[b] = 1'b1;
          else if (MODE == 0)     nxt_z[b] = 1'b1;
        end
      endcase
    end
  end

  // Output register and trireg charge store; both only move on an accepted transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.res_val   <= '0;
      bus.res_x     <= '1;
      bus.res_z     <= '0;
      bus.conflict  <= 1'b0;
      charge_val    <= '0;
      charge_x      <= '1;
      for (int b = 0; b < W; b++) cnt[b] <= '0;
    end else if (xfer) begin
      bus.out_valid <= 1'b1;
      bus.res_val   <= nxt_val;
      bus.res_x     <= nxt_x;
      bus.res_z     <= nxt_z;
      bus.conflict  <= conflict_nxt;
      charge_val    <= nxt_cval;
      charge_x      <= nxt_cx;
      cnt           <= nxt_cnt;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef NET_RESOLVE_STATS_EN
  logic [16:0] decay_sum;

  assign decay_sum = {1'b0, stat_decay} + 17'($countones(decayed));

  // Saturating statistics, updated once per accepted transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_xfer     <= '0;
      stat_conflict <= '0;
      stat_decay    <= '0;
    end else if (xfer) begin
      if (stat_xfer != 16'hFFFF) stat_xfer <= stat_xfer + 16'd1;
      if (conflict_nxt && stat_conflict != 16'hFFFF) stat_conflict <= stat_conflict + 16'd1;
      stat_decay <= decay_sum[16] ? 16'hFFFF : decay_sum[15:0];
    end
  end
`endif

endmodule
